matvec_stream_ctrl: RTL
=======================

# matvec_stream_ctrl

Streaming controller for the `matvec_mul` pipelined matrix-vector datapath. It holds the weight matrix in a local register and accepts input vectors over a valid/ready handshake. It tracks each vector through the `DEPTH+1`-stage multiply/adder-tree pipeline with a valid shift register, drives the datapath's global clock enable to apply output backpressure, and allows weight reloads only when the pipeline has drained. It sits between the vector source (DMA/FIFO) and the result sink, and instantiates one `matvec_mul`.

## Interface
- `R`, 8, matrix rows / output vector length
- `C`, 8, matrix columns / input vector length
- `W_X`, 8, signed input element width
- `W_K`, 8, signed weight element width
- `CNT_W`, 32, width of statistics counters
- Derived: `DEPTH = $clog2(C)`, `LAT = DEPTH+1`, `W_Y = W_X+W_K+DEPTH`
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `k_valid`  in  1  weight-load request
- `k_ready`  out  1  weight load accepted this cycle when `k_valid & k_ready`
- `k_in`  in  R·C·W_K  signed weights, packed `[R-1:0][C-1:0][W_K-1:0]`
- `s_valid`  in  1  input vector valid
- `s_ready`  out  1  input vector accepted when `s_valid & s_ready`
- `s_x`  in  C·W_X  signed input vector, packed `[C-1:0][W_X-1:0]`
- `m_valid`  out  1  result valid
- `m_ready`  in  1  sink ready
- `m_y`  out  R·W_Y  signed result, packed `[R-1:0][W_Y-1:0]`
- `busy`  out  1  at least one vector in flight
- `in_cnt`  out  CNT_W  vectors accepted since reset, wraps
- `out_cnt`  out  CNT_W  results delivered since reset, wraps
- `stall_cnt`  out  CNT_W  cycles with `m_valid & ~m_ready`, wraps

## Operation
- Internal `vld[LAT-1:0]` tags the pipeline stages. `m_valid = vld[LAT-1]`. `m_y` is driven directly by `matvec_mul.y`. `busy = |vld`.
- Datapath enable: `cen = ~m_valid | m_ready`. When `cen` is 0, the whole datapath and `vld` freeze. When `cen` is 1, `vld` shifts by one stage and `vld[0]` loads the accept bit.
- `s_ready = cen & ~k_valid`. A pending weight load blocks new vectors so the pipeline can drain. A vector is accepted iff `s_valid & s_ready`.
- `s_x` feeds the datapath `x` directly. Cycles with `cen` set but no accept inject a bubble (`vld[0]=0`); the garbage data in that slot is never presented as valid.
- Weights are stored in register `k_reg`, which drives the datapath `k`.
- `k_ready = ~busy & ~rst`. On `k_valid & k_ready`, `k_reg <= k_in`. No vector can be accepted in that same cycle because `s_ready` is low.
- Weight reloads are therefore atomic between vectors. Every result is computed with a single weight set.
- Arithmetic is the datapath's: `y[r] = Σ_c k[r][c]·x[c]`, signed, full precision in `W_Y` bits, with no overflow possible. Columns are zero-padded to a power of two internally.
- Counters:
  - `in_cnt` increments on each accept.
  - `out_cnt` increments on `m_valid & m_ready`.
  - `stall_cnt` increments on `m_valid & ~m_ready`.
  - All three wrap modulo 2^CNT_W.
- Reset:
  - `vld`, `k_reg` and all counters clear to 0.
  - Outputs: `m_valid=0`, `busy=0`, `s_ready=0` and `k_ready=0` during reset.
  - `m_y` is undefined until the first valid result; the datapath has no reset.
- Reset mid-operation discards all in-flight vectors. No result for them is ever produced.
- `k_valid` is not expected to drop before it is accepted. If it does drop early, no load occurs and vector acceptance resumes.

## Timing
- Latency with no stall: a vector accepted in cycle t gives `m_valid=1` in cycle t+LAT. Example: C=8 gives LAT=4; C=1 gives LAT=1.
- Throughput is one vector per cycle while `m_ready=1`.
- A stall is a global freeze: a result held at the output for N cycles delays every in-flight vector by N cycles. Bubbles are not collapsed.
- `s_ready` depends combinationally on `m_ready`, `m_valid` and `k_valid`. `m_valid` is registered.
- Weight reload cost: after the last vector is accepted, `k_ready` rises once `busy` falls. That takes at least LAT cycles, plus any stall cycles. The first vector after the load can be accepted in the cycle after the load.
- Simultaneous `m_valid & m_ready` with a new accept: the output slot advances and the new vector enters in the same cycle.

## Test plan
- **Single vector.** R=2, C=4, W_X=W_K=8 (LAT=3, W_Y=18). Load k=[[1,2,3,4],[-1,-1,-1,-1]], send x=[1,1,1,1], hold `m_ready=1`. Expect `m_valid` 3 cycles after accept, y=[10,-4], `in_cnt=out_cnt=1`.
- **Extremes.** k row0 all -128, row1 all 127; x all 127. Expect y=[-65024, 64516] with no truncation. Also x all -128 with row0 -128: expect y0=65536.
- **Streaming with backpressure.** Send 8 back-to-back vectors; drop `m_ready` for 5 cycles while result 2 is valid. Expect all 8 results in order, `m_y` stable while stalled, `s_ready=0` during the stall, `stall_cnt=5`.
- **Weight reload mid-stream.** Raise `k_valid` with 2 vectors in flight. Expect `s_ready=0` immediately, `k_ready=1` only after both results are delivered, and later vectors computed with the new k only.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 vectors in flight. Expect `m_valid=0` forever after until a new accept, all counters 0, and the following vector correct (with k=0 after reset, y=0).
- **Random.** Random `s_valid`/`m_ready`/`k_valid` over 10k cycles against a reference model. Expect no lost or duplicated results, `in_cnt - out_cnt = popcount(vld)` every cycle, and `C=1` / `C=5` builds passing.

Source files
------------

// File: rtl/matvec_stream_ctrl.sv
// Streaming controller around a pipelined matrix-vector multiplier: weight register,
// valid/ready input, valid-tag pipeline tracking, global-enable backpressure, statistics.

module matvec_mul #(
  parameter  int unsigned R     = 8,
  parameter  int unsigned C     = 8,
  parameter  int unsigned W_X   = 8,
  parameter  int unsigned W_K   = 8,
  localparam int unsigned DEPTH = $clog2(C),
  localparam int unsigned CP    = 1 << DEPTH,
  localparam int unsigned W_Y   = W_X + W_K + DEPTH
) (
  input  logic                         clk_i,
  input  logic                         en_i,
  input  logic [R-1:0][C-1:0][W_K-1:0] k_i,
  input  logic [C-1:0][W_X-1:0]        x_i,
  output logic [R-1:0][W_Y-1:0]        y_o
);

  // Node outputs per tree level; level 0 holds the registered products.
  logic signed [W_Y-1:0] lvl_c [DEPTH+1][R][CP];

  for (genvar gl = 0; gl <= DEPTH; gl++) begin : g_lvl
    for (genvar gr = 0; gr < R; gr++) begin : g_row
      for (genvar gj = 0; gj < CP; gj++) begin : g_node
        if (gl == 0 && gj < C) begin : g_leaf
          logic signed [W_Y-1:0] node_q;
          always_ff @(posedge clk_i) begin
            if (en_i) begin
              node_q <= W_Y'($signed(k_i[gr][gj])) * W_Y'($signed(x_i[gj]));
            end
          end
          assign lvl_c[gl][gr][gj] = node_q;
        end else if (gl > 0 && gj < (CP >> gl)) begin : g_add
          logic signed [W_Y-1:0] node_q;
          always_ff @(posedge clk_i) begin
            if (en_i) begin
              node_q <= lvl_c[gl-1][gr][2*gj] + lvl_c[gl-1][gr][2*gj+1];
            end
          end
          assign lvl_c[gl][gr][gj] = node_q;
        end else begin : g_pad
          // Zero-padded columns and unused upper-level slots.
          assign lvl_c[gl][gr][gj] = '0;
        end
      end
    end
  end

  for (genvar gr = 0; gr < R; gr++) begin : g_out
    assign y_o[gr] = lvl_c[DEPTH][gr][0];
  end

endmodule

module matvec_stream_ctrl #(
  parameter  int unsigned R     = 8,
  parameter  int unsigned C     = 8,
  parameter  int unsigned W_X   = 8,
  parameter  int unsigned W_K   = 8,
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned DEPTH = $clog2(C),
  localparam int unsigned LAT   = DEPTH + 1,
  localparam int unsigned W_Y   = W_X + W_K + DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         k_valid_i,
  output logic                         k_ready_o,
  input  logic [R-1:0][C-1:0][W_K-1:0] k_in_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [C-1:0][W_X-1:0]        s_x_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [R-1:0][W_Y-1:0]        m_y_o,
  output logic                         busy_o,
  output logic [CNT_W-1:0]             in_cnt_o,
  output logic [CNT_W-1:0]             out_cnt_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  logic [LAT-1:0]               vld_q, vld_d;
  logic [R-1:0][C-1:0][W_K-1:0] k_reg_q, k_reg_d;
  logic [CNT_W-1:0]             in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]             out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic                         cen_c;
  logic                         accept_c;
  logic                         k_load_c;

  // Handshakes and next-state; a stalled output freezes the whole pipeline.
  always_comb begin
    m_valid_o   = vld_q[LAT-1];
    busy_o      = |vld_q;
    cen_c       = ~m_valid_o | m_ready_i;
    s_ready_o   = cen_c & ~k_valid_i & ~rst_i;
    k_ready_o   = ~busy_o & ~rst_i;
    accept_c    = s_valid_i & s_ready_o;
    k_load_c    = k_valid_i & k_ready_o;
    vld_d       = vld_q;
    k_reg_d     = k_reg_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (cen_c) begin
      vld_d = (vld_q << 1) | LAT'(accept_c);
    end
    if (k_load_c) begin
      k_reg_d = k_in_i;
    end
    if (accept_c) begin
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end
    if (m_valid_o && m_ready_i) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
    if (m_valid_o && !m_ready_i) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q       <= '0;
      k_reg_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      k_reg_q     <= k_reg_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_cnt_o    = in_cnt_q;
  assign out_cnt_o   = out_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  matvec_mul #(
    .R   (R),
    .C   (C),
    .W_X (W_X),
    .W_K (W_K)
  ) u_matvec_mul (
    .clk_i (clk_i),
    .en_i  (cen_c),
    .k_i   (k_reg_q),
    .x_i   (s_x_i),
    .y_o   (m_y_o)
  );

endmodule
